usb_link_sequencer: RTL and testbench

- Parametrised successor to the USB link-layer transaction controller.
- Sits between the CRC5/CRC16 RX/TX datapaths and the control-TX block, sequencing one full transaction: token, then data, then handshake.
- Adds over the previous generation:
  - an explicit transaction FSM;
  - configurable timer and turnaround widths;
  - bounded master retry on timeout;
  - NAK/STALL decoding;
  - a per-transaction status report.

---
 rtl/usb_link_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_usb_link_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_link_sequencer.sv
// usb_link_sequencer: USB link-layer transaction sequencer.
// Runs one token -> data -> handshake transaction for either bus role.
// It drives the receive/transmit enables and the bus output enable.
// It times out missing responses, retries timed-out master transactions a bounded
// number of times, and reports a per-transaction status.
// Optional build macro: USB_SETUP_TOKEN_EN. When it is defined, SETUP (1101)
// starts an OUT-type transaction.
module usb_link_sequencer #(
  parameter int TIMER_W   = 16,
  parameter int DELAY_W   = 6,
  parameter int MAX_RETRY = 3,
  parameter int RETRY_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ms,
  input  logic               rx_pid_en,
  input  logic [3:0]         rx_pid,
  input  logic               rx_sop_en,
  input  logic               rx_lt_eop_en,
  input  logic               tx_con_pid_en,
  input  logic [3:0]         tx_con_pid,
  input  logic               tx_lp_eop_en,
  input  logic [TIMER_W-1:0] time_threshold,
  input  logic [DELAY_W-1:0] delay_threshold,
  input  logic               time_out_clr,
  output logic               rx_data_on,
  output logic               rx_handshake_on,
  output logic               tx_data_on,
  output logic               d_oe,
  output logic               time_out,
  output logic               retry_req,
  output logic               xfer_done,
  output logic [1:0]         xfer_status,
  output logic [RETRY_W-1:0] retry_cnt
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TX_TOKEN = 3'd1,
    S_TX_DATA  = 3'd2,
    S_RX_DATA  = 3'd3,
    S_TX_HS    = 3'd4,
    S_RX_HS    = 3'd5,
    S_TURN     = 3'd6
  } state_t;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
`ifdef USB_SETUP_TOKEN_EN
  localparam logic [3:0] PID_SETUP = 4'b1101;
`endif

  localparam logic [1:0] ST_ACK     = 2'd0;
  localparam logic [1:0] ST_NAK     = 2'd1;
  localparam logic [1:0] ST_STALL   = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  // OUT-type token decode; SETUP joins OUT when the optional feature is built in.
  function automatic logic is_out_type(input logic [3:0] pid);
`ifdef USB_SETUP_TOKEN_EN
    return (pid == PID_OUT) || (pid == PID_SETUP);
`else
    return (pid == PID_OUT);
`endif
  endfunction

  state_t               state_r, state_s;
  state_t               turn_next_r, turn_next_s;
  logic                 ms_r, ms_s;
  logic                 dir_in_r, dir_in_s;
  logic [DELAY_W-1:0]   turn_cnt_r;
  logic [TIMER_W-1:0]   timer_r;
  logic                 sop_seen_r;
  logic                 timeout_s;
  logic                 done_s;
  logic [1:0]           status_s;
  logic                 retry_s;
  logic                 set_to_s;
  logic                 d_oe_s;

  // State, latched role/direction and the TURN successor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      turn_next_r <= S_IDLE;
      ms_r        <= 1'b0;
      dir_in_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      turn_next_r <= turn_next_s;
      ms_r        <= ms_s;
      dir_in_r    <= dir_in_s;
    end
  end

  // Response timeout decode. A response seen on the threshold cycle counts as arrived.
  always_comb begin
    timeout_s = 1'b0;
    if (state_r == S_RX_DATA) begin
      timeout_s = !sop_seen_r && !rx_sop_en && !rx_lt_eop_en && (timer_r == time_threshold);
    end else if (state_r == S_RX_HS) begin
      timeout_s = (timer_r == time_threshold);
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Next-state and per-transaction event decode.
  always_comb begin
    state_s     = state_r;
    turn_next_s = turn_next_r;
    ms_s        = ms_r;
    dir_in_s    = dir_in_r;
    done_s      = 1'b0;
    status_s    = ST_ACK;
    retry_s     = 1'b0;
    set_to_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (ms) begin
          if (tx_con_pid_en && is_out_type(tx_con_pid)) begin
            state_s  = S_TX_TOKEN;
            ms_s     = 1'b1;
            dir_in_s = 1'b0;
          end else if (tx_con_pid_en && (tx_con_pid == PID_IN)) begin
            state_s  = S_TX_TOKEN;
            ms_s     = 1'b1;
            dir_in_s = 1'b1;
          end else begin
            state_s = S_IDLE;
          end
        end else begin
          if (rx_pid_en && is_out_type(rx_pid)) begin
            state_s  = S_RX_DATA;
            ms_s     = 1'b0;
            dir_in_s = 1'b0;
          end else if (rx_pid_en && (rx_pid == PID_IN)) begin
            state_s  = S_TX_DATA;
            ms_s     = 1'b0;
            dir_in_s = 1'b1;
          end else begin
            state_s = S_IDLE;
          end
        end
      end
      S_TX_TOKEN: begin
        if (tx_lp_eop_en) begin
          if (dir_in_r) begin
            state_s     = S_TURN;
            turn_next_s = S_RX_DATA;
          end else begin
            state_s = S_TX_DATA;
          end
        end else begin
          state_s = S_TX_TOKEN;
        end
      end
      S_TX_DATA: begin
        if (tx_lp_eop_en) begin
          state_s     = S_TURN;
          turn_next_s = S_RX_HS;
        end else begin
          state_s = S_TX_DATA;
        end
      end
      S_TURN: begin
        if (turn_cnt_r == delay_threshold) begin
          state_s = turn_next_r;
          if (turn_next_r == S_IDLE) begin
            done_s   = 1'b1;
            status_s = ST_ACK;
          end else begin
            done_s = 1'b0;
          end
        end else begin
          state_s = S_TURN;
        end
      end
      S_RX_DATA: begin
        if (rx_lt_eop_en) begin
          state_s = S_TX_HS;
        end else if (timeout_s) begin
          state_s = S_IDLE;
          if (ms_r && (retry_cnt < RETRY_LIMIT)) begin
            retry_s = 1'b1;
          end else begin
            done_s   = 1'b1;
            status_s = ST_TIMEOUT;
            set_to_s = 1'b1;
          end
        end else begin
          state_s = S_RX_DATA;
        end
      end
      S_TX_HS: begin
        if (tx_lp_eop_en) begin
          if (ms_r) begin
            state_s  = S_IDLE;
            done_s   = 1'b1;
            status_s = ST_ACK;
          end else begin
            state_s     = S_TURN;
            turn_next_s = S_IDLE;
          end
        end else begin
          state_s = S_TX_HS;
        end
      end
      S_RX_HS: begin
        if (rx_pid_en && (rx_pid == PID_ACK)) begin
          state_s  = S_IDLE;
          done_s   = 1'b1;
          status_s = ST_ACK;
        end else if (rx_pid_en && (rx_pid == PID_NAK)) begin
          state_s  = S_IDLE;
          done_s   = 1'b1;
          status_s = ST_NAK;
        end else if (rx_pid_en && (rx_pid == PID_STALL)) begin
          state_s  = S_IDLE;
          done_s   = 1'b1;
          status_s = ST_STALL;
        end else if (timeout_s) begin
          state_s = S_IDLE;
          if (ms_r && (retry_cnt < RETRY_LIMIT)) begin
            retry_s = 1'b1;
          end else begin
            done_s   = 1'b1;
            status_s = ST_TIMEOUT;
            set_to_s = 1'b1;
          end
        end else begin
          state_s = S_RX_HS;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Bus output enable for the state being entered. In IDLE it follows the role input.
  always_comb begin
    d_oe_s = 1'b1;
    case (state_s)
      S_IDLE:                                  d_oe_s = ms;
      S_TX_TOKEN, S_TX_DATA, S_TX_HS, S_TURN:  d_oe_s = 1'b1;
      S_RX_DATA, S_RX_HS:                      d_oe_s = 1'b0;
      default:                                 d_oe_s = 1'b1;
    endcase
  end

  // Turnaround counter: cleared on entry to TURN, counts while in TURN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      turn_cnt_r <= '0;
    end else if ((state_s == S_TURN) && (state_r != S_TURN)) begin
      turn_cnt_r <= '0;
    end else if (state_r == S_TURN) begin
      turn_cnt_r <= turn_cnt_r + DELAY_W'(1);
    end else begin
      turn_cnt_r <= turn_cnt_r;
    end
  end

  // Response timer: cleared on entry to a receive state. It freezes after start-of-packet in RX_DATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_r    <= '0;
      sop_seen_r <= 1'b0;
    end else if (((state_s == S_RX_DATA) || (state_s == S_RX_HS)) && (state_s != state_r)) begin
      timer_r    <= '0;
      sop_seen_r <= 1'b0;
    end else if (state_r == S_RX_DATA) begin
      if (!sop_seen_r && !rx_sop_en) begin
        timer_r <= timer_r + TIMER_W'(1);
      end else begin
        timer_r <= timer_r;
      end
      sop_seen_r <= sop_seen_r | rx_sop_en;
    end else if (state_r == S_RX_HS) begin
      timer_r <= timer_r + TIMER_W'(1);
    end else begin
      timer_r <= timer_r;
    end
  end

  // Registered enables and per-transaction event outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_on      <= 1'b0;
      rx_handshake_on <= 1'b0;
      tx_data_on      <= 1'b0;
      d_oe            <= 1'b1;
      retry_req       <= 1'b0;
      xfer_done       <= 1'b0;
      xfer_status     <= 2'd0;
    end else begin
      rx_data_on      <= (state_s == S_RX_DATA);
      rx_handshake_on <= (state_s == S_RX_HS);
      tx_data_on      <= (state_s == S_TX_DATA);
      d_oe            <= d_oe_s;
      retry_req       <= retry_s;
      xfer_done       <= done_s;
      xfer_status     <= done_s ? status_s : 2'd0;
    end
  end

  // Retry count carries across reissued tokens. It clears when the transaction finishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_cnt <= '0;
    end else if (done_s) begin
      retry_cnt <= '0;
    end else if (retry_s) begin
      retry_cnt <= retry_cnt + RETRY_W'(1);
    end else begin
      retry_cnt <= retry_cnt;
    end
  end

  // Sticky timeout flag. A new timeout wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_out <= 1'b0;
    end else if (set_to_s) begin
      time_out <= 1'b1;
    end else if (time_out_clr) begin
      time_out <= 1'b0;
    end else begin
      time_out <= time_out;
    end
  end

endmodule

// File: tb/tb_usb_link_sequencer.sv
// Directed self-checking bench for usb_link_sequencer (default parameters).
module tb_usb_link_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ms = 1'b1;
  logic        rx_pid_en = 1'b0;
  logic [3:0]  rx_pid = 4'd0;
  logic        rx_sop_en = 1'b0;
  logic        rx_lt_eop_en = 1'b0;
  logic        tx_con_pid_en = 1'b0;
  logic [3:0]  tx_con_pid = 4'd0;
  logic        tx_lp_eop_en = 1'b0;
  logic [15:0] time_threshold = 16'd100;
  logic [5:0]  delay_threshold = 6'd2;
  logic        time_out_clr = 1'b0;
  logic        rx_data_on, rx_handshake_on, tx_data_on, d_oe;
  logic        time_out, retry_req, xfer_done;
  logic [1:0]  xfer_status;
  logic [1:0]  retry_cnt;

  int checks = 0;
  int failures = 0;

  usb_link_sequencer dut (
    .clk(clk), .rst(rst), .ms(ms),
    .rx_pid_en(rx_pid_en), .rx_pid(rx_pid), .rx_sop_en(rx_sop_en),
    .rx_lt_eop_en(rx_lt_eop_en), .tx_con_pid_en(tx_con_pid_en),
    .tx_con_pid(tx_con_pid), .tx_lp_eop_en(tx_lp_eop_en),
    .time_threshold(time_threshold), .delay_threshold(delay_threshold),
    .time_out_clr(time_out_clr), .rx_data_on(rx_data_on),
    .rx_handshake_on(rx_handshake_on), .tx_data_on(tx_data_on), .d_oe(d_oe),
    .time_out(time_out), .retry_req(retry_req), .xfer_done(xfer_done),
    .xfer_status(xfer_status), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tok(input logic [3:0] pid);
    tx_con_pid = pid; tx_con_pid_en = 1'b1; step(); tx_con_pid_en = 1'b0;
  endtask

  task automatic eop();
    tx_lp_eop_en = 1'b1; step(); tx_lp_eop_en = 1'b0;
  endtask

  task automatic rxpid(input logic [3:0] pid);
    rx_pid = pid; rx_pid_en = 1'b1; step(); rx_pid_en = 1'b0;
  endtask

  // Outputs that must all be at reset values.
  task automatic chk_reset(input string tag);
    chk({tag, "_rxd"}, rx_data_on, 1'b0);
    chk({tag, "_rxhs"}, rx_handshake_on, 1'b0);
    chk({tag, "_txd"}, tx_data_on, 1'b0);
    chk({tag, "_doe"}, d_oe, 1'b1);
    chk({tag, "_to"}, time_out, 1'b0);
    chk({tag, "_rr"}, retry_req, 1'b0);
    chk({tag, "_done"}, xfer_done, 1'b0);
    chk({tag, "_st"}, xfer_status, 2'd0);
    chk({tag, "_rc"}, retry_cnt, 2'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    step(); step();
    chk_reset("rst");
    rst = 1'b0;
    step();
    chk("idle_doe_master", d_oe, 1'b1);

    // Master OUT, delay 2, ACK five cycles into RX_HS
    time_threshold = 16'd100;
    tok(4'b0001);
    chk("mout_tok_txd", tx_data_on, 1'b0);
    chk("mout_tok_doe", d_oe, 1'b1);
    eop();
    chk("mout_txd", tx_data_on, 1'b1);
    chk("mout_txd_doe", d_oe, 1'b1);
    step();
    chk("mout_txd_hold", tx_data_on, 1'b1);
    eop();
    chk("mout_turn_txd", tx_data_on, 1'b0);
    chk("mout_turn_doe0", d_oe, 1'b1);
    step();
    chk("mout_turn_doe1", d_oe, 1'b1);
    step();
    chk("mout_turn_doe2", d_oe, 1'b1);
    step();
    chk("mout_rxhs_doe", d_oe, 1'b0);
    chk("mout_rxhs_on", rx_handshake_on, 1'b1);
    for (int i = 0; i < 4; i++) step();
    chk("mout_rxhs_wait", rx_handshake_on, 1'b1);
    rxpid(4'b0010);
    chk("mout_done", xfer_done, 1'b1);
    chk("mout_status", xfer_status, 2'd0);
    chk("mout_rc", retry_cnt, 2'd0);
    chk("mout_hs_off", rx_handshake_on, 1'b0);
    chk("mout_idle_doe", d_oe, 1'b1);
    step();
    chk("mout_done_pulse", xfer_done, 1'b0);

    // Master IN, threshold 10, no data: three retries, then a timeout report
    time_threshold = 16'd10;
    for (int a = 0; a < 4; a++) begin
      tok(4'b1001);
      eop();
      step(); step();
      chk("min_turn_rxd", rx_data_on, 1'b0);
      step();
      chk("min_rxd_on", rx_data_on, 1'b1);
      chk("min_rxd_doe", d_oe, 1'b0);
      for (int k = 0; k < 10; k++) step();
      chk("min_rxd_pre_to", rx_data_on, 1'b1);
      chk("min_no_rr_yet", retry_req, 1'b0);
      step();
      chk("min_rxd_off", rx_data_on, 1'b0);
      if (a < 3) begin
        chk("min_rr", retry_req, 1'b1);
        chk("min_rc", retry_cnt, a + 1);
        chk("min_no_done", xfer_done, 1'b0);
        chk("min_no_to", time_out, 1'b0);
      end else begin
        chk("min_final_rr", retry_req, 1'b0);
        chk("min_final_done", xfer_done, 1'b1);
        chk("min_final_st", xfer_status, 2'd3);
        chk("min_final_to", time_out, 1'b1);
        chk("min_final_rc", retry_cnt, 2'd0);
      end
      step();
      chk("min_rr_pulse", retry_req, 1'b0);
    end
    chk("min_to_sticky", time_out, 1'b1);
    time_out_clr = 1'b1; step(); time_out_clr = 1'b0;
    chk("min_to_clr", time_out, 1'b0);

    // Slave IN received, STALL returned
    time_threshold = 16'd100;
    ms = 1'b0;
    step();
    chk("sin_idle_doe", d_oe, 1'b0);
    rxpid(4'b1001);
    chk("sin_txd", tx_data_on, 1'b1);
    chk("sin_txd_doe", d_oe, 1'b1);
    eop();
    chk("sin_turn_doe", d_oe, 1'b1);
    chk("sin_turn_txd", tx_data_on, 1'b0);
    step(); step();
    chk("sin_turn_doe2", d_oe, 1'b1);
    step();
    chk("sin_rxhs_doe", d_oe, 1'b0);
    chk("sin_rxhs_on", rx_handshake_on, 1'b1);
    step(); step();
    rxpid(4'b1110);
    chk("sin_done", xfer_done, 1'b1);
    chk("sin_status", xfer_status, 2'd2);
    chk("sin_idle_doe2", d_oe, 1'b0);

    // Slave OUT received, data end at cycle 20 (timer frozen by start of packet)
    time_threshold = 16'd10;
    rxpid(4'b0001);
    chk("sout_rxd", rx_data_on, 1'b1);
    chk("sout_rxd_doe", d_oe, 1'b0);
    step(); step();
    rx_sop_en = 1'b1; step(); rx_sop_en = 1'b0;
    for (int k = 0; k < 16; k++) step();
    chk("sout_rxd_hold", rx_data_on, 1'b1);
    chk("sout_no_to", time_out, 1'b0);
    chk("sout_no_done", xfer_done, 1'b0);
    rx_lt_eop_en = 1'b1; step(); rx_lt_eop_en = 1'b0;
    chk("sout_txhs_doe", d_oe, 1'b1);
    chk("sout_txhs_rxd", rx_data_on, 1'b0);
    eop();
    chk("sout_turn_doe0", d_oe, 1'b1);
    chk("sout_turn_nodone", xfer_done, 1'b0);
    step(); step();
    chk("sout_turn_doe2", d_oe, 1'b1);
    step();
    chk("sout_idle_doe", d_oe, 1'b0);
    chk("sout_done", xfer_done, 1'b1);
    chk("sout_status", xfer_status, 2'd0);

    // NAK on the same cycle the RX_HS timer reaches threshold
    ms = 1'b1;
    time_threshold = 16'd5;
    step();
    tok(4'b0001);
    eop();
    eop();
    step(); step(); step();
    chk("nak_rxhs_on", rx_handshake_on, 1'b1);
    for (int k = 0; k < 5; k++) step();
    chk("nak_rxhs_still", rx_handshake_on, 1'b1);
    rxpid(4'b1010);
    chk("nak_done", xfer_done, 1'b1);
    chk("nak_status", xfer_status, 2'd1);
    chk("nak_no_rr", retry_req, 1'b0);
    chk("nak_rc", retry_cnt, 2'd0);
    chk("nak_no_to", time_out, 1'b0);

    // Build up one retry, then reset in the middle of TX_DATA
    time_threshold = 16'd3;
    tok(4'b1001);
    eop();
    step(); step(); step();
    for (int k = 0; k < 3; k++) step();
    step();
    chk("rst_prep_rr", retry_req, 1'b1);
    chk("rst_prep_rc", retry_cnt, 2'd1);
    time_threshold = 16'd100;
    tok(4'b0001);
    eop();
    chk("rst_prep_txd", tx_data_on, 1'b1);
    rst = 1'b1;
    step();
    chk_reset("midrst");
    rst = 1'b0;
    step();
    chk("post_rst_txd", tx_data_on, 1'b0);

    // SETUP token as master
    tok(4'b1101);
    eop();
`ifdef USB_SETUP_TOKEN_EN
    chk("setup_txd", tx_data_on, 1'b1);
    eop();
    step(); step(); step();
    chk("setup_rxhs", rx_handshake_on, 1'b1);
    rxpid(4'b0010);
    chk("setup_done", xfer_done, 1'b1);
    chk("setup_status", xfer_status, 2'd0);
`else
    chk("setup_ign_txd", tx_data_on, 1'b0);
    chk("setup_ign_doe", d_oe, 1'b1);
    eop();
    step(); step(); step();
    chk("setup_ign_rxhs", rx_handshake_on, 1'b0);
    chk("setup_ign_done", xfer_done, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
